gf2m_mul_serial: RTL and testbench
==================================

Name: gf2m_mul_serial

Overview:
- Bit-serial, MSB-first multiplier over GF(2^N) with a fixed irreducible polynomial f(x) = x^N + POLY(x).
- It is the forward counterpart of the datapath's inverter. It computes OUT = A·B mod f, so feeding it (A, A^-1) must return 1.
- It is used both as the ECC field multiplier and as the self-check partner for inversion results.
- One product per transaction, using valid/ready handshakes on both input and output.

Parameters:
- N, 5, field degree (bit width of operands and result); legal range 2..1023.
- POLY, 5'b00101, low N bits of f(x), i.e. f minus its x^N term. The default gives f = x^5 + x^2 + 1. POLY[0] must be 1.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RST_N  input  1  reset, synchronous, active-low.
- A  input  N  multiplicand. Any N-bit value is already a reduced field element.
- B  input  N  multiplier.
- IN_VALID  input  1  A and B are valid this cycle.
- IN_READY  output  1  block can accept an operand pair.
- OUT  output  N  product A·B mod f.
- OUT_VALID  output  1  OUT holds a finished product.
- OUT_READY  input  1  consumer accepts OUT this cycle.
- BUSY  output  1  a multiplication is in progress (RUN state).

Behaviour:
- Reset (RST_N sampled low at a rising edge):
  - state = IDLE; acc, a_reg, b_reg, cnt = 0.
  - OUT = 0, OUT_VALID = 0, IN_READY = 1, BUSY = 0.
  - Reset has priority over every other condition.
- Reset mid-operation: any RUN or DONE work is discarded. No OUT_VALID is produced for it.
- States:
  - IDLE: IN_READY = 1. On an edge with IN_VALID = 1:
    - a_reg <= A, b_reg <= B, acc <= 0, cnt <= N-1; go to RUN.
    - IN_VALID = 0: stay in IDLE.
  - RUN: IN_READY = 0, BUSY = 1. Each edge performs one step:
    - acc <= xtime(acc) XOR (b_reg[cnt] ? a_reg : 0).
    - xtime(v) = {v[N-2:0], 1'b0} XOR (v[N-1] ? POLY : 0). It is an N-bit shift with reduction.
    - When cnt = 0: OUT <= the new acc value, OUT_VALID <= 1, go to DONE.
    - Otherwise cnt <= cnt - 1.
  - DONE: OUT_VALID = 1, IN_READY = 0, BUSY = 0; OUT stays stable.
    - On an edge with OUT_READY = 1: OUT_VALID <= 0, go to IDLE.
    - Otherwise hold; backpressure is unlimited.
- Latency:
  - Accept edge E0. RUN occupies edges E1..EN.
  - OUT_VALID is high starting right after edge EN, i.e. N cycles after acceptance.
  - Minimum throughput is one product per N+2 cycles when OUT_READY is held high.
- Handshake rules:
  - An input is consumed only when IN_VALID and IN_READY are both high at an edge.
  - IN_VALID asserted while IN_READY = 0 is ignored. The operands are not queued.
  - A and B may change freely after the accept edge.
- Output rules:
  - OUT keeps the last product after the handshake. It is rewritten only at the end of the next RUN.
  - OUT_READY is a don't-care outside DONE.
- Counter: cnt is 10 bits wide and counts down. No wrap occurs because RUN exits when cnt = 0.
- Arithmetic:
  - Addition is XOR; no carries.
  - acc never exceeds N bits. Reduction uses POLY only when the bit shifted out is 1.
- Edge cases:
  - A = 0 or B = 0: still takes the full N cycles; the result is 0.
  - B = 1: result equals A.
  - Back-to-back transactions: IN_READY rises in the cycle after the OUT handshake edge. There is no same-cycle bypass.

Test Plan:
- Inverse check (N=5, POLY=00101): A=0x02, B=0x12, OUT_READY=1 -> OUT=0x01, with OUT_VALID high exactly 5 cycles after the accept edge.
- Reduction: A=0x02, B=0x10 -> 0x05. A=0x10, B=0x10 -> 0x0D. A=0x1F, B=0x1F -> 0x12.
- Identity and zero: A=0x1F, B=0x01 -> 0x1F. A=0x00, B=0x1B -> 0x00, also after 5 cycles.
- Backpressure and ignored input:
  - Hold OUT_READY=0 for 20 cycles in DONE -> OUT and OUT_VALID stay stable and IN_READY stays 0.
  - Pulse IN_VALID during RUN/DONE -> it is ignored, and the next product matches only the first operands.
  - Release OUT_READY -> OUT_VALID drops, and IN_READY=1 on the next cycle.
- Reset mid-RUN: assert RST_N=0 for 1 cycle at cycle 3 of RUN -> OUT=0, OUT_VALID=0, IN_READY=1; no spurious OUT_VALID afterwards.
- Random regression: 1000 random (A, B) pairs with random OUT_READY stalls, compared against a software GF(2^5) model. Every nonzero A is also paired with its inverse from the inversion block and must give 0x01.

Source files
------------

// File: rtl/gf2m_mul_serial.sv
// Bit-serial MSB-first GF(2^N) multiplier, OUT = A*B mod (x^N + POLY).
// One product per transaction with valid/ready on both the operand and result sides.
module gf2m_mul_serial #(
  parameter int unsigned   N    = 5,
  parameter logic [N-1:0]  POLY = N'(5'b00101)
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         IN_VALID,
  output logic         IN_READY,
  output logic [N-1:0] OUT,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic         BUSY
);

  localparam int unsigned CW = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [N-1:0]   acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   out_q, out_d;
  logic           out_valid_q, out_valid_d;
  logic           in_ready_q, in_ready_d;
  logic           busy_q, busy_d;
  logic [N-1:0]   step_c;

  // One Horner step: acc*x mod f, plus A if the current multiplier bit is set.
  // b_q is shifted left each step so its MSB is always the bit cnt points at.
  always_comb begin
    step_c = {acc_q[N-2:0], 1'b0} ^ (acc_q[N-1] ? POLY : '0) ^ (b_q[N-1] ? a_q : '0);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (IN_VALID) begin
          a_d     = A;
          b_d     = B;
          acc_d   = '0;
          cnt_d   = CW'(N - 1);
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = step_c;
        b_d   = b_q << 1;
        if (cnt_q == '0) begin
          out_d       = step_c;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        if (OUT_READY) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    // Status flags track the next state so they are registered alongside it.
    in_ready_d = (state_d == IDLE);
    busy_d     = (state_d == RUN);
  end

  assign IN_READY  = in_ready_q;
  assign BUSY      = busy_q;
  assign OUT       = out_q;
  assign OUT_VALID = out_valid_q;

endmodule

// File: tb/tb_gf2m_mul_serial.sv
// Scoreboard bench for gf2m_mul_serial: directed field products, backpressure, reset
// mid-operation and randomized operands checked against a polynomial-arithmetic model.
module tb_gf2m_mul_serial;

  localparam int unsigned N    = 5;
  localparam logic [N-1:0] POLY = 5'b00101;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic [N-1:0] A, B, OUT;
  logic         IN_VALID, IN_READY, OUT_VALID, OUT_READY, BUSY;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic [N-1:0] exp_q[$];
  logic rnd_rdy = 1'b0;
  logic rdy_force = 1'b1;

  gf2m_mul_serial #(.N(N), .POLY(POLY)) dut (
    .CLK(CLK), .RST_N(RST_N), .A(A), .B(B), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .OUT(OUT), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Consumer side: random stalls or a forced level, changed just after each edge.
  always @(posedge CLK) begin
    #1;
    OUT_READY = rnd_rdy ? ($urandom_range(0, 3) != 0) : rdy_force;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference: carry-less polynomial product, then long division by f(x).
  function automatic logic [N-1:0] gf_mul(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [2*N-2:0] p;
    logic [2*N-2:0] f;
    p = '0;
    f = (2*N-1)'(POLY) | ((2*N-1)'(1) << N);
    for (int i = 0; i < int'(N); i++)
      if (b[i]) p ^= (2*N-1)'(a) << i;
    for (int k = 2*N-2; k >= int'(N); k--)
      if (p[k]) p ^= f << (k - int'(N));
    return p[N-1:0];
  endfunction

  // Inverse as a^(2^N - 2) in the multiplicative group.
  function automatic logic [N-1:0] gf_inv(input logic [N-1:0] a);
    logic [N-1:0] r;
    r = N'(1);
    for (int i = 0; i < (1 << N) - 2; i++) r = gf_mul(r, a);
    return r;
  endfunction

  // Monitor: the DUT hands over a product on every edge with OUT_VALID && OUT_READY.
  always @(negedge CLK) begin
    if (RST_N && OUT_VALID && OUT_READY) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out_valid", 32'(OUT_VALID), 32'(0));
      end else begin
        chk("product", 32'(OUT), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] exp);
    int t;
    t = 0;
    @(posedge CLK); #1;
    A = a; B = b; IN_VALID = 1'b1;
    @(negedge CLK);
    while (!IN_READY && t < 200) begin
      @(negedge CLK);
      t++;
    end
    if (!IN_READY) chk("accept_timeout", 32'(IN_READY), 32'(1));
    @(posedge CLK); #1;
    exp_q.push_back(exp);
    acc_cyc = cyc;
    IN_VALID = 1'b0;
    A = N'($urandom); B = N'($urandom);
  endtask

  task automatic wait_valid(input logic level, input string name);
    int t;
    t = 0;
    @(negedge CLK);
    while (OUT_VALID !== level && t < 200) begin
      @(negedge CLK);
      t++;
    end
    if (OUT_VALID !== level) chk(name, 32'(OUT_VALID), 32'(level));
  endtask

  // Directed product with latency and RUN-state status checks.
  task automatic directed(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] exp,
                          input string name);
    issue(a, b, exp);
    @(negedge CLK);
    chk({name, "_busy"}, 32'({BUSY, IN_READY}), 32'(2'b10));
    wait_valid(1'b1, {name, "_timeout"});
    chk({name, "_latency"}, 32'(cyc - acc_cyc), 32'(N));
    wait_valid(1'b0, {name, "_drop_timeout"});
  endtask

  initial begin
    logic [N-1:0] hold;
    logic stable, no_valid;
    RST_N = 1'b0; A = '0; B = '0; IN_VALID = 1'b0; OUT_READY = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;
    chk("reset_out", 32'(OUT), 32'(0));
    chk("reset_flags", 32'({OUT_VALID, IN_READY, BUSY}), 32'(3'b010));

    directed(5'h02, 5'h12, 5'h01, "inverse");
    directed(5'h02, 5'h10, 5'h05, "red_x5");
    directed(5'h10, 5'h10, 5'h0D, "red_x8");
    directed(5'h1F, 5'h1F, 5'h12, "red_full");
    directed(5'h1F, 5'h01, 5'h1F, "identity");
    directed(5'h00, 5'h1B, 5'h00, "zero");

    // Backpressure, with operand pulses in RUN and DONE that must be ignored.
    rdy_force = 1'b0;
    @(posedge CLK);
    issue(5'h05, 5'h07, 5'h1B);
    IN_VALID = 1'b1; A = 5'h1F; B = 5'h1F;
    repeat (2) @(posedge CLK);
    #1 IN_VALID = 1'b0;
    wait_valid(1'b1, "bp_timeout");
    hold = OUT;
    chk("bp_product", 32'(hold), 32'(5'h1B));
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        @(posedge CLK); #1 IN_VALID = 1'b1; A = 5'h03; B = 5'h03;
        @(posedge CLK); #1 IN_VALID = 1'b0;
      end
      @(negedge CLK);
      if (OUT !== hold || OUT_VALID !== 1'b1 || IN_READY !== 1'b0 || BUSY !== 1'b0) stable = 1'b0;
    end
    chk("bp_hold_stable", 32'(stable), 32'(1));
    rdy_force = 1'b1;
    wait_valid(1'b0, "bp_release_timeout");
    chk("bp_release_in_ready", 32'(IN_READY), 32'(1));
    chk("bp_out_kept", 32'(OUT), 32'(hold));
    repeat (2 * N) @(negedge CLK);
    chk("bp_no_extra", 32'(exp_q.size() + 32'(OUT_VALID)), 32'(0));

    // Reset in the third RUN cycle discards the operation.
    issue(5'h13, 5'h0B, gf_mul(5'h13, 5'h0B));
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b0;
    exp_q.delete();
    @(posedge CLK);
    #1 RST_N = 1'b1;
    chk("midreset_out", 32'(OUT), 32'(0));
    chk("midreset_flags", 32'({OUT_VALID, IN_READY, BUSY}), 32'(3'b010));
    no_valid = 1'b1;
    repeat (3 * N) begin
      @(negedge CLK);
      if (OUT_VALID !== 1'b0) no_valid = 1'b0;
    end
    chk("midreset_no_valid", 32'(no_valid), 32'(1));

    // Randomized regression with consumer stalls, then every inverse pair.
    rnd_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      logic [N-1:0] ra, rb;
      ra = N'($urandom); rb = N'($urandom);
      issue(ra, rb, gf_mul(ra, rb));
    end
    for (int a = 1; a < (1 << N); a++) issue(N'(a), gf_inv(N'(a)), N'(1));

    rnd_rdy = 1'b0;
    rdy_force = 1'b1;
    begin
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 500) begin
        @(negedge CLK);
        t++;
      end
      chk("drain", 32'(exp_q.size()), 32'(0));
    end
    repeat (2) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
